// File: rtl/frogger_grid_pkg.sv
// rtl/frogger_grid_pkg.sv - shared tile grid geometry defaults
package frogger_grid_pkg;

    localparam int TILE_W = 32;
    localparam int TILE_H = 32;
    localparam int COLS   = 20;
    localparam int ROWS   = 15;
    localparam int GRID_W = 640;
    localparam int GRID_H = 480;

    // Width needed to hold values 0..n inclusive, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tile_grid_tracker_if.sv
// rtl/tile_grid_tracker_if.sv - raster strobes in, tile coordinates out
interface tile_grid_tracker_if #(
    parameter int COL_W = 5,
    parameter int ROW_W = 4,
    parameter int TX_W  = 5,
    parameter int TY_W  = 5
);
    logic             sof;
    logic             pix_en;
    logic             eol;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [TX_W-1:0]  tx;
    logic [TY_W-1:0]  ty;
    logic             in_grid;
    logic             tile_first;
    logic             row_first;

    modport master (
        output sof, pix_en, eol,
        input  col, row, tx, ty, in_grid, tile_first, row_first
    );

    modport slave (
        input  sof, pix_en, eol,
        output col, row, tx, ty, in_grid, tile_first, row_first
    );
endinterface

// File: rtl/axis_tile_counter.sv
// rtl/axis_tile_counter.sv - per-axis tile offset counter with saturating tile index
module axis_tile_counter
    import frogger_grid_pkg::*;
#(
    parameter int TILE  = 32,
    parameter int COUNT = 20,
    parameter int OFF_W = $clog2(TILE),
    parameter int IDX_W = idx_width(COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    output logic [OFF_W-1:0] off,
    output logic [IDX_W-1:0] idx,
    output logic             first
);

    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(TILE - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(COUNT);

    logic [OFF_W-1:0] r_off;
    logic [IDX_W-1:0] r_idx;

    // Offset wraps every TILE steps and bumps the index, which parks at COUNT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_off <= '0;
            r_idx <= '0;
        end else if (clr) begin
            r_off <= '0;
            r_idx <= '0;
        end else if (step) begin
            if (r_off == OFF_MAX) begin
                r_off <= '0;
                if (r_idx != IDX_MAX) begin
                    r_idx <= r_idx + 1'b1;
                end
            end else begin
                r_off <= r_off + 1'b1;
            end
        end
    end

    assign off   = r_off;
    assign idx   = r_idx;
    assign first = (r_off == '0);

endmodule

// File: rtl/tile_grid_tracker.sv
// rtl/tile_grid_tracker.sv - tile column/row and in-tile offset tracker for the raster
module tile_grid_tracker
    import frogger_grid_pkg::*;
#(
    parameter int TILE_W = frogger_grid_pkg::TILE_W,
    parameter int TILE_H = frogger_grid_pkg::TILE_H,
    parameter int COLS   = frogger_grid_pkg::COLS,
    parameter int ROWS   = frogger_grid_pkg::ROWS
) (
    input  logic                clk,
    input  logic                rst_n,
    tile_grid_tracker_if.slave  bus
);

    localparam int TX_W  = $clog2(TILE_W);
    localparam int TY_W  = $clog2(TILE_H);
    localparam int COL_W = idx_width(COLS);
    localparam int ROW_W = idx_width(ROWS);

    logic w_x_clr;
    logic w_y_step;

    // A line end already accounts for any pixel strobed with it, so it clears x
    // instead of stepping; a frame start overrides the line advance
    assign w_x_clr  = bus.sof | bus.eol;
    assign w_y_step = bus.eol & ~bus.sof;

    axis_tile_counter #(
        .TILE  (TILE_W),
        .COUNT (COLS),
        .OFF_W (TX_W),
        .IDX_W (COL_W)
    ) u_x_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_x_clr),
        .step  (bus.pix_en),
        .off   (bus.tx),
        .idx   (bus.col),
        .first (bus.tile_first)
    );

    axis_tile_counter #(
        .TILE  (TILE_H),
        .COUNT (ROWS),
        .OFF_W (TY_W),
        .IDX_W (ROW_W)
    ) u_y_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.sof),
        .step  (w_y_step),
        .off   (bus.ty),
        .idx   (bus.row),
        .first (bus.row_first)
    );

    assign bus.in_grid = (bus.col < COL_W'(COLS)) && (bus.row < ROW_W'(ROWS));

endmodule

// File: tb/tb_tile_grid_tracker.sv
// tb/tb_tile_grid_tracker.sv - directed bench for tile_grid_tracker, default and odd geometries
module tb_tile_grid_tracker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sof = 1'b0;
    logic pix_en = 1'b0;
    logic eol = 1'b0;

    int checks = 0;
    int errors = 0;
    int x = 0;
    int y = 0;

    always #5 clk = ~clk;

    tile_grid_tracker_if #(.COL_W(5), .ROW_W(4), .TX_W(5), .TY_W(5)) bus_a ();
    tile_grid_tracker_if #(.COL_W(5), .ROW_W(5), .TX_W(5), .TY_W(5)) bus_b ();

    assign bus_a.sof = sof;
    assign bus_a.pix_en = pix_en;
    assign bus_a.eol = eol;
    assign bus_b.sof = sof;
    assign bus_b.pix_en = pix_en;
    assign bus_b.eol = eol;

    tile_grid_tracker dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    tile_grid_tracker #(.TILE_W(24), .TILE_H(20), .COLS(26), .ROWS(24)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    function automatic int sat_div(input int v, input int t, input int c);
        return (v / t > c) ? c : v / t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference position follows the same priority, then both DUTs see the edge
    task automatic tick();
        if (sof) begin
            x = 0;
            y = 0;
        end else if (eol) begin
            x = 0;
            y++;
        end else if (pix_en) begin
            x++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, " a.col"}, 32'(bus_a.col), sat_div(x, 32, 20));
        check({tag, " a.tx"}, 32'(bus_a.tx), x % 32);
        check({tag, " a.row"}, 32'(bus_a.row), sat_div(y, 32, 15));
        check({tag, " a.ty"}, 32'(bus_a.ty), y % 32);
        check({tag, " a.in_grid"}, 32'(bus_a.in_grid), 32'((x / 32 < 20) && (y / 32 < 15)));
        check({tag, " a.tile_first"}, 32'(bus_a.tile_first), 32'(x % 32 == 0));
        check({tag, " a.row_first"}, 32'(bus_a.row_first), 32'(y % 32 == 0));
        check({tag, " b.col"}, 32'(bus_b.col), sat_div(x, 24, 26));
        check({tag, " b.tx"}, 32'(bus_b.tx), x % 24);
        check({tag, " b.row"}, 32'(bus_b.row), sat_div(y, 20, 24));
        check({tag, " b.ty"}, 32'(bus_b.ty), y % 20);
        check({tag, " b.in_grid"}, 32'(bus_b.in_grid), 32'((x / 24 < 26) && (y / 20 < 24)));
        check({tag, " b.tile_first"}, 32'(bus_b.tile_first), 32'(x % 24 == 0));
        check({tag, " b.row_first"}, 32'(bus_b.row_first), 32'(y % 20 == 0));
    endtask

    task automatic do_sof();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic pixels(input int n);
        pix_en = 1'b1;
        repeat (n) tick();
        pix_en = 1'b0;
    endtask

    task automatic lines(input int n);
        eol = 1'b1;
        repeat (n) tick();
        eol = 1'b0;
    endtask

    initial begin
        // 1: reset state, then asynchronous clear from mid-count
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        tick();
        pixels(5 * 32 + 7);
        check("pre_rst a.col", 32'(bus_a.col), 5);
        check("pre_rst a.tx", 32'(bus_a.tx), 7);
        #2;
        rst_n = 1'b0;
        x = 0;
        y = 0;
        #1;
        check_all("async_rst");
        tick();
        rst_n = 1'b1;
        tick();

        // 2: one full line of pixels
        do_sof();
        pix_en = 1'b1;
        for (int i = 0; i < 640; i++) begin
            if (i == 31) begin
                check("px31 col", 32'(bus_a.col), 0);
                check("px31 tx", 32'(bus_a.tx), 31);
            end
            if (i == 32) begin
                check("px32 col", 32'(bus_a.col), 1);
                check("px32 tx", 32'(bus_a.tx), 0);
                check("px32 tile_first", 32'(bus_a.tile_first), 1);
            end
            if (i == 639) begin
                check("px639 col", 32'(bus_a.col), 19);
                check("px639 tx", 32'(bus_a.tx), 31);
            end
            check_all($sformatf("line px%0d", i));
            tick();
        end
        pix_en = 1'b0;
        check("px640 col", 32'(bus_a.col), 20);
        check("px640 in_grid", 32'(bus_a.in_grid), 0);
        check_all("line end");

        // 3: a frame of short lines
        do_sof();
        for (int l = 0; l < 480; l++) begin
            if (l == 32) begin
                check("ln32 row", 32'(bus_a.row), 1);
                check("ln32 ty", 32'(bus_a.ty), 0);
                check("ln32 row_first", 32'(bus_a.row_first), 1);
            end
            if (l == 479) begin
                check("ln479 row", 32'(bus_a.row), 14);
                check("ln479 ty", 32'(bus_a.ty), 31);
            end
            check_all($sformatf("frame ln%0d", l));
            pixels(1);
            check_all($sformatf("frame ln%0d px", l));
            lines(1);
        end
        check("frame end row", 32'(bus_a.row), 15);
        check("frame end in_grid", 32'(bus_a.in_grid), 0);
        check_all("frame end");

        // 4: non-power-of-2 geometry on dut_b
        do_sof();
        pixels(50);
        check("b x50 col", 32'(bus_b.col), 2);
        check("b x50 tx", 32'(bus_b.tx), 2);
        do_sof();
        lines(41);
        check("b y41 row", 32'(bus_b.row), 2);
        check("b y41 ty", 32'(bus_b.ty), 1);
        check_all("b y41");
        for (int t = 0; t < 6; t++) begin
            do_sof();
            lines(int'($urandom_range(0, 520)));
            pixels(int'($urandom_range(0, 700)));
            check_all($sformatf("rand%0d x%0d y%0d", t, x, y));
        end

        // 5: collisions
        do_sof();
        pixels(10);
        lines(3);
        pixels(5);
        pix_en = 1'b1;
        eol = 1'b1;
        tick();
        check("eol+pix tx", 32'(bus_a.tx), 0);
        check("eol+pix ty", 32'(bus_a.ty), 4);
        check_all("eol+pix");
        sof = 1'b1;
        tick();
        sof = 1'b0;
        eol = 1'b0;
        pix_en = 1'b0;
        check("sof+all ty", 32'(bus_a.ty), 0);
        check_all("sof+all");

        // 6: overrun past the grid edge
        do_sof();
        pixels(700);
        check("ovr a.col", 32'(bus_a.col), 20);
        check("ovr a.tx", 32'(bus_a.tx), 28);
        check("ovr b.col", 32'(bus_b.col), 26);
        check("ovr b.tx", 32'(bus_b.tx), 4);
        check_all("overrun");
        lines(1);
        check("ovr eol a.col", 32'(bus_a.col), 0);
        check_all("overrun eol");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
